// File: rtl/mux_2x1.sv
// rtl/mux_2x1.sv - registered 2:1 mux with optional select-change counter (MUX_2X1_SWITCH_COUNT_EN)
module mux_2x1 #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             out_sel
`ifdef MUX_2X1_SWITCH_COUNT_EN
   ,
   output logic [CNT_W-1:0] switch_count
`endif
);

   // Capture the selected input and its select on every accepted sample; hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_sel   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out     <= sel ? b : a;
            out_sel <= sel;
         end
      end
   end

`ifdef MUX_2X1_SWITCH_COUNT_EN
   // out_sel only means "previous accepted sel" once a sample has been taken since reset.
   logic first_seen;

   // Count select changes between consecutive accepted samples, saturating at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_seen   <= 1'b0;
         switch_count <= '0;
      end else if (in_valid) begin
         first_seen <= 1'b1;
         if (first_seen && (sel != out_sel) && (switch_count != {CNT_W{1'b1}})) begin
            switch_count <= switch_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mux_2x1.sv
// tb/tb_mux_2x1.sv - directed self-checking bench for mux_2x1 (WIDTH=8 and WIDTH=1/CNT_W=2 instances)
module tb_mux_2x1;

   logic       clk = 1'b0;
   logic       rst;
   logic       sel;
   logic       in_valid;
   logic [7:0] a8, b8, out8;
   logic [0:0] a1, b1, out1;
   logic       out_valid8, out_sel8, out_valid1, out_sel1;
`ifdef MUX_2X1_SWITCH_COUNT_EN
   logic [7:0] cnt8;
   logic [1:0] cnt1;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_2x1 #(.WIDTH(8), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(sel), .in_valid(in_valid),
      .out(out8), .out_valid(out_valid8), .out_sel(out_sel8)
`ifdef MUX_2X1_SWITCH_COUNT_EN
      , .switch_count(cnt8)
`endif
   );

   mux_2x1 #(.WIDTH(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel), .in_valid(in_valid),
      .out(out1), .out_valid(out_valid1), .out_sel(out_sel1)
`ifdef MUX_2X1_SWITCH_COUNT_EN
      , .switch_count(cnt1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   logic [7:0] tt_exp;
   logic [7:0] exp_a, exp_b;
   logic       exp_s;

   initial begin
      rst = 1'b1; sel = 1'b0; in_valid = 1'b0;
      a8 = '0; b8 = '0; a1 = '0; b1 = '0;
      tt_exp = 8'b1101_1000;  // bit i = expected out for {a,b,sel}=i

      // Reset state
      #3;
      check("rst_out8", out8, 0);
      check("rst_valid8", out_valid8, 0);
      check("rst_sel8", out_sel8, 0);
      check("rst_out1", out1, 0);
`ifdef MUX_2X1_SWITCH_COUNT_EN
      check("rst_cnt8", cnt8, 0);
`endif
      tick();
      rst = 1'b0;

      // Truth table on WIDTH=1
      for (int i = 0; i < 8; i++) begin
         {a1[0], b1[0], sel} = 3'(i);
         in_valid = 1'b1;
         tick();
         check($sformatf("tt_out_%0d", i), out1, tt_exp[i]);
         check($sformatf("tt_sel_%0d", i), out_sel1, i % 2);
         check($sformatf("tt_vld_%0d", i), out_valid1, 1);
      end
      in_valid = 1'b0;
      tick();
      check("tt_vld_drop", out_valid1, 0);

      // Hold on WIDTH=8
      do_reset();
      a8 = 8'h3C; b8 = 8'h99; sel = 1'b0; in_valid = 1'b1;
      tick();
      check("hold_load", out8, 8'h3C);
      check("hold_load_vld", out_valid8, 1);
      a8 = 8'hFF; sel = 1'b1; in_valid = 1'b0;
      tick();
      check("hold_out", out8, 8'h3C);
      check("hold_vld", out_valid8, 0);
      check("hold_sel", out_sel8, 0);

      // Asynchronous reset between edges
      a8 = 8'hA5; sel = 1'b0; in_valid = 1'b1;
      tick();
      check("async_pre", out8, 8'hA5);
      #2 rst = 1'b1;
      #1;
      check("async_out", out8, 0);
      check("async_vld", out_valid8, 0);
`ifdef MUX_2X1_SWITCH_COUNT_EN
      check("async_cnt", cnt8, 0);
`endif
      // Sample presented while rst is held is discarded
      a8 = 8'h5A; in_valid = 1'b1;
      tick();
      check("rst_discard", out8, 0);
      check("rst_discard_vld", out_valid8, 0);
      rst = 1'b0;
      in_valid = 1'b0;
      tick();

`ifdef MUX_2X1_SWITCH_COUNT_EN
      // Counter: sel 0,1,1,0,1 -> 3
      do_reset();
      in_valid = 1'b1;
      foreach (tt_exp[i]) begin end
      for (int i = 0; i < 5; i++) begin
         sel = (5'b10110 >> i) & 1'b1;   // 0,1,1,0,1
         tick();
      end
      in_valid = 1'b0;
      check("cnt_seq8", cnt8, 3);
      check("cnt_seq1", cnt1, 3);

      // First sample after reset with sel=1 is not a switch; then saturation on CNT_W=2
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         sel = ~i[0];                    // 1,0,1,0,1,0
         tick();
         if (i == 0) check("cnt_first", cnt8, 0);
      end
      in_valid = 1'b0;
      check("cnt_alt8", cnt8, 5);
      check("cnt_sat1", cnt1, 3);
      tick();
      check("cnt_hold", cnt8, 5);
`endif

      // Streaming: 10 back-to-back samples, alternating sel
      do_reset();
      for (int i = 0; i < 10; i++) begin
         exp_a = 8'(i * 17 + 3);
         exp_b = 8'(~(i * 29));
         exp_s = i[0];
         a8 = exp_a; b8 = exp_b; sel = exp_s; in_valid = 1'b1;
         tick();
         check($sformatf("strm_out_%0d", i), out8, exp_s ? exp_b : exp_a);
         check($sformatf("strm_vld_%0d", i), out_valid8, 1);
         check($sformatf("strm_sel_%0d", i), out_sel8, exp_s);
      end
      in_valid = 1'b0;
      tick();
      check("strm_end_vld", out_valid8, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_2x1.md
MUX_2X1 -- requirements
Module: mux_2x1

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the data width of a, b and out.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of switch_count.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset; it is asynchronous and active-high.
REQ-005 Port a, input, WIDTH, SHALL be data input 0, selected when sel=0.
REQ-006 Port b, input, WIDTH, SHALL be data input 1, selected when sel=1.
REQ-007 Port sel, input, 1, SHALL be the select: 0 picks a, 1 picks b.
REQ-008 Port in_valid, input, 1, SHALL qualify a, b and sel for capture.
REQ-009 Port out, output, WIDTH, SHALL be the registered selected data.
REQ-010 Port out_valid, output, 1, SHALL flag that out was updated on the last edge.
REQ-011 Port out_sel, output, 1, SHALL be the sel value that produced the current out.
REQ-012 Port switch_count, output, CNT_W, SHALL be the saturating count of select changes; it exists only when the macro in REQ-025 is defined.

Function
REQ-013 On a rising clk edge with in_valid=1, out SHALL load b if sel=1, else a; the latency is 1 cycle.
REQ-014 On a rising clk edge with in_valid=1, out_sel SHALL load sel.
REQ-015 On a rising clk edge with in_valid=0, out and out_sel SHALL hold their values.
REQ-016 out_valid SHALL load in_valid on every rising edge, so it is high for exactly one cycle per accepted sample.
REQ-017 Selection SHALL be bitwise on all WIDTH bits, with no reordering, inversion or truncation.
REQ-018 Back-to-back accepted samples SHALL be processed one per cycle, with no stall and no backpressure.
REQ-019 If a, b or sel change between edges, they SHALL have no effect until the next edge with in_valid=1.
REQ-020 The first accepted sample after reset SHALL NOT count as a switch.
REQ-021 Each later accepted sample whose sel differs from the previously accepted sel SHALL increment switch_count by 1.
REQ-022 switch_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.

Reset
REQ-023 When rst=1, the block SHALL immediately force, independent of clk: out=0, out_sel=0, out_valid=0, switch_count=0, and clear the "first sample seen" flag.
REQ-024 If rst asserts mid-stream, any sample on that edge SHALL be discarded; the first accepted sample after rst deasserts SHALL be treated as the first sample (REQ-020).

Configuration
REQ-025 Macro MUX_2X1_SWITCH_COUNT_EN SHALL control the select-change counter.
- Defined: the switch_count port and its counter logic are present.
- Undefined: the port and the logic are absent, and REQ-013 to REQ-019 are unchanged.

Verification
REQ-026 Truth table, WIDTH=1, in_valid=1: drive (a,b,sel) = 000,001,010,011,100,101,110,111 on successive edges -> out one cycle later = 0,0,0,1,1,0,1,1 and out_sel = sel.
REQ-027 Hold: WIDTH=8, sample a=0x3C, sel=0 -> out=0x3C; then in_valid=0 with a=0xFF -> out stays 0x3C, out_valid=0.
REQ-028 Async reset: assert rst between edges with out=0xA5 -> out, out_valid and switch_count go to 0 before the next edge.
REQ-029 Counter (macro defined): accepted sel sequence 0,1,1,0,1 -> switch_count=3; CNT_W=2 with 5 alternations -> switch_count saturates at 3.
REQ-030 Streaming: in_valid high 10 consecutive cycles with alternating sel -> out_valid high for 10 consecutive cycles, and each out matches its input of 1 cycle earlier.
